stage_if_prefetch: RTL and testbench
====================================

STAGE_IF_PREFETCH -- requirements
Module: stage_if_prefetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: PC and memory address width.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_VECTOR, default 0: PC value loaded at reset.
REQ-004 Port clock  input  1: the block's sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high.
REQ-006 Port stall  input  1: 1 blocks issue of new fetch requests.
REQ-007 Port redirect_enable  input  1: 1 redirects fetch and flushes the queue.
REQ-008 Port redirect_pc  input  ADDR_WIDTH: redirect target.
REQ-009 Port mem_req  output  1: fetch request valid.
REQ-010 Port mem_addr  output  ADDR_WIDTH: fetch address.
REQ-011 Port mem_ready  input  1: memory accepts the request this cycle.
REQ-012 Port mem_rvalid  input  1: in-order read response valid.
REQ-013 Port mem_rdata  input  32: instruction word.
REQ-014 Port out_valid  output  1: queue head valid toward decode.
REQ-015 Port out_pc  output  ADDR_WIDTH: PC of head instruction.
REQ-016 Port out_insn  output  32: head instruction.
REQ-017 Port out_ready  input  1: decode consumes the head.
REQ-018 Port out_misalign  output  1: head is a misaligned-fetch marker; present only with STAGE_IF_MISALIGN_EN.

Function
REQ-019 Request handshake: a request is accepted in a cycle with mem_req=1 and mem_ready=1; mem_addr equals fetch_pc.
REQ-020 mem_req is 1 only when stall=0, redirect_enable=0, and occupancy + outstanding < DEPTH; it is never asserted in the reset cycle.
REQ-021 On an accepted request, fetch_pc advances by 4, wrapping modulo 2^ADDR_WIDTH, and outstanding increments.
REQ-022 Responses return in order; each valid response decrements outstanding and pushes {pc, insn} into the queue, unless it is being dropped.
REQ-023 Pop occurs when out_valid=1 and out_ready=1; push and pop in the same cycle are both honoured, and occupancy is unchanged.
REQ-024 The queue never overflows, because requests are credit-limited under REQ-020.
REQ-025 out_valid, out_pc and out_insn are registered-queue outputs; an empty-queue push becomes visible on the next cycle.
REQ-026 Redirect: in the cycle redirect_enable=1, fetch_pc loads redirect_pc; the queue empties on the next edge; any pop or push in that cycle is discarded.
REQ-027 On redirect, drop_count loads the outstanding count, including a request accepted in the same cycle; later responses are discarded while drop_count>0, and each discarded response decrements drop_count.
REQ-028 A response arriving in the redirect cycle itself is discarded and is not counted in drop_count.
REQ-029 Back-to-back redirects: the last redirect wins, and drop counts accumulate correctly.
REQ-030 stall does not affect out_valid or popping.

Reset
REQ-031 On reset: fetch_pc=RESET_VECTOR, queue empty, outstanding=0, drop_count=0, mem_req=0, out_valid=0, out_pc=0, out_insn=0, out_misalign=0.
REQ-032 Reset mid-operation abandons all outstanding requests; the memory side is also reset by the same signal.

Configuration
REQ-033 With STAGE_IF_MISALIGN_EN defined, a redirect_pc with [1:0]!=0 stops request issue and pushes one entry {pc=redirect_pc, insn=0, misalign=1} once drop_count reaches 0; issue then halts until the next redirect.
REQ-034 Without STAGE_IF_MISALIGN_EN, redirect_pc[1:0] is forced to 2'b00 and port out_misalign is absent.

Structure
REQ-035 RESET_ENABLE, STALL_DISABLE and WRITE_ENABLE-style constants and the instruction width come from the shared CPU defines package.
REQ-036 The queue is a sub-module fetch_queue: parametrised synchronous FIFO with push, pop, flush, count, and head output.

Verification
REQ-037 Reset, then mem_ready=1 and rvalid one cycle later, out_ready=1 -> mem_addr sequence 0, 4, 8, …; out_pc 0, 4, 8 in order with matching out_insn.
REQ-038 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req=0; after one pop, exactly one further request.
REQ-039 Two requests outstanding, redirect to 0x100 -> both stale responses dropped; the next out_pc is 0x100, and no stale entry appears.
REQ-040 stall=1 for 3 cycles with a non-empty queue -> no requests; the queue drains to decode normally.
REQ-041 fetch_pc 0xFFFFFFFC (ADDR_WIDTH=32) -> the next request address is 0x00000000.
REQ-042 With STAGE_IF_MISALIGN_EN, redirect to 0x102 -> one entry with out_misalign=1 and out_pc=0x102, and mem_req stays 0 until the next redirect.

Source files
------------

// File: rtl/stage_if_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// stage_if_prefetch_pkg
// Shared CPU defines used by the instruction-fetch prefetch stage: control
// level constants, instruction width, PC step and a small alignment helper.
// ----------------------------------------------------------------------------
package stage_if_prefetch_pkg;

    localparam int unsigned INSN_WIDTH    = 32;
    localparam int unsigned PC_STEP       = 4;

    localparam logic        RESET_ENABLE  = 1'b1;
    localparam logic        STALL_DISABLE = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;

    // True when the two low PC bits do not describe a word-aligned fetch.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/stage_if_prefetch_if.sv
// ----------------------------------------------------------------------------
// stage_if_prefetch_if
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
//   mem_req/mem_addr   : fetch request, accepted when mem_ready is high
//   mem_rvalid/rdata   : in-order read response
// ----------------------------------------------------------------------------
interface stage_if_prefetch_if
    import stage_if_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
);

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [INSN_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/stage_if_prefetch_fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO holding fetched {pc, insn} entries for decode.
//   clock, reset  : clock, synchronous active-high reset
//   push_i        : write push_data_i at the tail
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the queue; same-cycle push/pop are discarded
//   count_o       : current occupancy
//   head_valid_o  : queue non-empty
//   head_data_o   : head entry, zero while empty
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_queue
    import stage_if_prefetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = (push_i == WRITE_ENABLE) && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != 0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by count_q and the head is masked while empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 0);
    assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/stage_if_prefetch.sv
// ----------------------------------------------------------------------------
// stage_if_prefetch
// Instruction-fetch prefetch stage: issues sequential fetch requests, queues
// in-order responses as {pc, insn} for decode, and handles redirects by
// flushing the queue and dropping responses still in flight.
//   clock, reset         : clock, synchronous active-high reset
//   stall                : blocks new fetch requests (not popping)
//   redirect_enable/pc   : restart fetch at redirect_pc, flush the queue
//   mem (master)         : request/response bus to instruction memory
//   out_valid/pc/insn    : queue head toward decode, out_ready pops it
//   out_misalign         : head is a misaligned-fetch marker
// Optional feature macro STAGE_IF_MISALIGN_EN: a misaligned redirect target
// halts issue and delivers a single marker entry; without it the target is
// forced word-aligned and out_misalign does not exist.
// ----------------------------------------------------------------------------
module stage_if_prefetch
    import stage_if_prefetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_enable,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    stage_if_prefetch_if.master   mem,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INSN_WIDTH-1:0] out_insn,
    input  logic                  out_ready
`ifdef STAGE_IF_MISALIGN_EN
    ,
    output logic                  out_misalign
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
`ifdef STAGE_IF_MISALIGN_EN
    localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + INSN_WIDTH;
`else
    localparam int unsigned ENTRY_W = ADDR_WIDTH + INSN_WIDTH;
`endif

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    // PC of the next response that will be kept. Requests after a redirect
    // are sequential, so surviving responses follow the target in steps of 4.
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      drop_count_q, drop_count_d;

    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  credit_ok;
    logic                  issue_halt;
    logic                  accept;
    logic                  resp_push;

    logic                  q_push;
    logic                  q_pop;
    logic [ENTRY_W-1:0]    q_push_data;
    logic [CNT_W-1:0]      q_count;
    logic                  q_head_valid;
    logic [ENTRY_W-1:0]    q_head_data;

`ifdef STAGE_IF_MISALIGN_EN
    logic halt_q, halt_d;
    logic pending_q, pending_d;
    logic mis_push;

    assign redirect_target = redirect_pc;
    assign issue_halt      = halt_q;
`else
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
    assign issue_halt      = 1'b0;
`endif

    // Queue entries plus in-flight requests never exceed DEPTH, so every
    // response that is kept always finds a free slot.
    assign credit_ok = (SUM_W'(q_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);

    assign mem.mem_req  = (reset != RESET_ENABLE) && (stall == STALL_DISABLE) &&
                          !redirect_enable && credit_ok && !issue_halt;
    assign mem.mem_addr = fetch_pc_q;
    assign accept       = mem.mem_req && mem.mem_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(mem.mem_rvalid);
        drop_count_d  = drop_count_q;
        resp_push     = 1'b0;
        q_pop         = 1'b0;
        if (redirect_enable) begin
            // Everything still in flight after this edge is stale; a response
            // arriving right now is already gone from outstanding_d.
            fetch_pc_d   = redirect_target;
            resp_pc_d    = redirect_target;
            drop_count_d = outstanding_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
            if (mem.mem_rvalid) begin
                if (drop_count_q != 0) begin
                    drop_count_d = drop_count_q - CNT_W'(1);
                end else begin
                    resp_push = 1'b1;
                    resp_pc_d = resp_pc_q + ADDR_WIDTH'(PC_STEP);
                end
            end
            q_pop = q_head_valid && out_ready;
        end
    end

`ifdef STAGE_IF_MISALIGN_EN
    // A misaligned target stops issue; the marker entry is queued once all
    // stale responses have drained, and issue stays halted until a redirect.
    always_comb begin
        halt_d    = halt_q;
        pending_d = pending_q;
        mis_push  = 1'b0;
        if (redirect_enable) begin
            halt_d    = is_misaligned(redirect_target[1:0]);
            pending_d = halt_d;
        end else if (pending_q && (drop_count_q == 0)) begin
            mis_push  = 1'b1;
            pending_d = 1'b0;
        end
    end

    assign q_push       = resp_push | mis_push;
    assign q_push_data  = mis_push ? {1'b1, fetch_pc_q, {INSN_WIDTH{1'b0}}}
                                   : {1'b0, resp_pc_q, mem.mem_rdata};
    assign out_misalign = q_head_data[ENTRY_W-1];
`else
    assign q_push       = resp_push;
    assign q_push_data  = {resp_pc_q, mem.mem_rdata};
`endif

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_count_q  <= '0;
`ifdef STAGE_IF_MISALIGN_EN
            halt_q        <= 1'b0;
            pending_q     <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
`ifdef STAGE_IF_MISALIGN_EN
            halt_q        <= halt_d;
            pending_q     <= pending_d;
`endif
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (q_push),
        .push_data_i  (q_push_data),
        .pop_i        (q_pop),
        .flush_i      (redirect_enable),
        .count_o      (q_count),
        .head_valid_o (q_head_valid),
        .head_data_o  (q_head_data)
    );

    assign out_valid = q_head_valid;
    assign out_pc    = q_head_data[INSN_WIDTH +: ADDR_WIDTH];
    assign out_insn  = q_head_data[INSN_WIDTH-1:0];

endmodule

// File: tb/tb_stage_if_prefetch.sv
// ----------------------------------------------------------------------------
// tb_stage_if_prefetch
// Bench for stage_if_prefetch. The reference keeps the decode queue and the
// list of in-flight requests as plain queues; a redirect marks every
// in-flight request stale instead of counting drops. The same in-flight list
// serves as the instruction memory, answering in order with insn_of(addr).
// Honours STAGE_IF_MISALIGN_EN when defined.
// ----------------------------------------------------------------------------
module tb_stage_if_prefetch;

    localparam int unsigned    AW    = 32;
    localparam int unsigned    DEPTH = 4;
    localparam logic [AW-1:0]  RV    = '0;

    logic          clock = 1'b1;
    logic          reset;
    logic          stall;
    logic          redirect_enable;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [31:0]   out_insn;
    logic          out_ready;
`ifdef STAGE_IF_MISALIGN_EN
    logic          out_misalign;
`endif

    stage_if_prefetch_if #(.ADDR_WIDTH(AW)) mem_bus ();

    stage_if_prefetch #(
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_enable (redirect_enable),
        .redirect_pc     (redirect_pc),
        .mem             (mem_bus),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_insn        (out_insn),
        .out_ready       (out_ready)
`ifdef STAGE_IF_MISALIGN_EN
        ,
        .out_misalign    (out_misalign)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        bit          mis;
    } entry_t;

    // Reference state
    flight_t     inflight[$];
    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_pending;

    // Bench bookkeeping
    int          n_cmp;
    int          n_fail;
    int          resp_prob;
    bit          skip_out;
    int          dut_req_cycles;
    logic [31:0] dut_acc[$];
    logic [31:0] dut_pop[$];
    logic [31:0] dut_pop_insn[$];
    bit          dut_pop_mis[$];

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] rpc);
`ifdef STAGE_IF_MISALIGN_EN
        return rpc;
`else
        return rpc & ~32'h3;
`endif
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        dut_acc.delete();
        dut_pop.delete();
        dut_pop_insn.delete();
        dut_pop_mis.delete();
        dut_req_cycles = 0;
    endtask

    // One clock cycle: the caller has set the control inputs; this drives the
    // memory response, compares outputs at the falling edge, advances the
    // reference, and returns just after the rising edge.
    task automatic cycle();
        bit      exp_req, exp_valid, accept, stale_before, resp_keep;
        flight_t e;
        entry_t  n;
        if (reset !== 1'b1 && inflight.size() > 0 && $urandom_range(99) < resp_prob) begin
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = inflight[0].data;
        end else begin
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = $urandom();
        end
        @(negedge clock);

        exp_req = !reset && !stall && !redirect_enable && !m_halt &&
                  (mq.size() + inflight.size() < DEPTH);
        check("mem_req", mem_bus.mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_bus.mem_addr, m_pc);
        exp_valid = (mq.size() > 0);
        if (!skip_out) begin
            check("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("out_pc", out_pc, mq[0].pc);
                check("out_insn", out_insn, mq[0].insn);
`ifdef STAGE_IF_MISALIGN_EN
                check("out_misalign", out_misalign, mq[0].mis);
`endif
            end
        end

        if (mem_bus.mem_req) dut_req_cycles++;
        if (mem_bus.mem_req && mem_bus.mem_ready) dut_acc.push_back(mem_bus.mem_addr);
        if (out_valid && out_ready && !redirect_enable && !reset) begin
            dut_pop.push_back(out_pc);
            dut_pop_insn.push_back(out_insn);
`ifdef STAGE_IF_MISALIGN_EN
            dut_pop_mis.push_back(out_misalign);
`endif
        end

        if (reset) begin
            mq.delete();
            inflight.delete();
            m_pc      = RV;
            m_halt    = 1'b0;
            m_pending = 1'b0;
        end else begin
            accept       = exp_req && mem_bus.mem_ready;
            stale_before = 1'b0;
            foreach (inflight[i]) if (inflight[i].stale) stale_before = 1'b1;
            resp_keep = 1'b0;
            if (mem_bus.mem_rvalid) begin
                e         = inflight.pop_front();
                resp_keep = !redirect_enable && !e.stale;
            end
            if (redirect_enable) begin
                mq.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_pc = target_of(redirect_pc);
`ifdef STAGE_IF_MISALIGN_EN
                m_halt    = (m_pc[1:0] != 2'b00);
                m_pending = m_halt;
`endif
            end else begin
                if (exp_valid && out_ready) void'(mq.pop_front());
                if (resp_keep) begin
                    n.pc = e.addr; n.insn = e.data; n.mis = 1'b0;
                    mq.push_back(n);
                end
                if (m_pending && !stale_before) begin
                    n.pc = m_pc; n.insn = '0; n.mis = 1'b1;
                    mq.push_back(n);
                    m_pending = 1'b0;
                end
                if (accept) begin
                    e.addr = m_pc; e.data = insn_of(m_pc); e.stale = 1'b0;
                    inflight.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        stall             = 1'b0;
        redirect_enable   = 1'b0;
        redirect_pc       = '0;
        mem_bus.mem_ready = 1'b0;
        out_ready         = 1'b0;
        resp_prob         = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_enable = 1'b1;
        redirect_pc     = pc;
        cycle();
        redirect_enable = 1'b0;
    endtask

    initial begin
        bit any_stale;
        n_cmp = 0; n_fail = 0;
        m_pc = RV; m_halt = 1'b0; m_pending = 1'b0;
        clear_logs();
        set_idle();
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;

        // Reset: outputs are unknown before the first edge, so only mem_req
        // is compared in that cycle.
        reset = 1'b1;
        skip_out = 1'b1;
        cycle();
        skip_out = 1'b0;
        check("rst_mem_req", mem_bus.mem_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_insn", out_insn, 32'h0);
        cycle();
        reset = 1'b0;

        // Streaming fetch from the reset vector.
        clear_logs();
        mem_bus.mem_ready = 1'b1; out_ready = 1'b1; resp_prob = 100;
        repeat (12) cycle();
        check("seq_acc0", at(dut_acc, 0), 32'h0);
        check("seq_acc1", at(dut_acc, 1), 32'h4);
        check("seq_acc2", at(dut_acc, 2), 32'h8);
        check("seq_pop0", at(dut_pop, 0), 32'h0);
        check("seq_pop1", at(dut_pop, 1), 32'h4);
        check("seq_pop2", at(dut_pop, 2), 32'h8);
        check("seq_insn0", at(dut_pop_insn, 0), insn_of(32'h0));
        check("seq_insn2", at(dut_pop_insn, 2), insn_of(32'h8));

        // Credit limit with decode blocked, then one pop frees one credit.
        do_reset();
        clear_logs();
        mem_bus.mem_ready = 1'b1; resp_prob = 100;
        repeat (10) cycle();
        check("credit_n_acc", dut_acc.size(), 4);
        check("credit_req_off", mem_bus.mem_req, 1'b0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        clear_logs();
        repeat (8) cycle();
        check("credit_n_acc_after_pop", dut_acc.size(), 1);
        check("credit_acc_after_pop", at(dut_acc, 0), 32'h10);

        // Stall with a full queue: no issue, decode keeps draining.
        clear_logs();
        stall = 1'b1; out_ready = 1'b1;
        repeat (3) cycle();
        check("stall_n_acc", dut_acc.size(), 0);
        check("stall_n_pop", dut_pop.size(), 3);
        check("stall_pop0", at(dut_pop, 0), 32'h4);
        check("stall_pop2", at(dut_pop, 2), 32'hC);
        stall = 1'b0;
        repeat (10) cycle();

        // Redirect with two requests in flight: both responses are dropped.
        do_reset();
        out_ready = 1'b1; mem_bus.mem_ready = 1'b1; resp_prob = 0;
        repeat (2) cycle();
        mem_bus.mem_ready = 1'b0;
        redirect_to(32'h100);
        clear_logs();
        mem_bus.mem_ready = 1'b1; resp_prob = 100;
        repeat (12) cycle();
        check("redir_pop0", at(dut_pop, 0), 32'h100);
        check("redir_pop1", at(dut_pop, 1), 32'h104);
        any_stale = 1'b0;
        foreach (dut_pop[i]) if (dut_pop[i] < 32'h100) any_stale = 1'b1;
        check("redir_no_stale", any_stale, 1'b0);

        // PC wrap at the top of the address space.
        redirect_to(32'hFFFF_FFFC);
        clear_logs();
        repeat (6) cycle();
        check("wrap_acc0", at(dut_acc, 0), 32'hFFFF_FFFC);
        check("wrap_acc1", at(dut_acc, 1), 32'h0);

`ifdef STAGE_IF_MISALIGN_EN
        // Misaligned target: one marker entry, issue halted until redirect.
        resp_prob = 50;
        repeat (3) cycle();
        redirect_to(32'h102);
        clear_logs();
        resp_prob = 100;
        repeat (10) cycle();
        check("mis_n_pop", dut_pop.size(), 1);
        check("mis_pop_pc", at(dut_pop, 0), 32'h102);
        check("mis_pop_flag", (dut_pop_mis.size() > 0) ? dut_pop_mis[0] : 1'b0, 1'b1);
        check("mis_pop_insn", at(dut_pop_insn, 0), 32'h0);
        check("mis_req_cycles", dut_req_cycles, 0);
        redirect_to(32'h200);
        clear_logs();
        repeat (4) cycle();
        check("mis_resume_acc0", at(dut_acc, 0), 32'h200);
`else
        // Misaligned target is forced to a word boundary.
        redirect_to(32'h102);
        clear_logs();
        repeat (6) cycle();
        check("align_acc0", at(dut_acc, 0), 32'h100);
        check("align_pop0", at(dut_pop, 0), 32'h100);
`endif

        // Randomised traffic against the reference.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom_range(999) < 3);
            stall           = ($urandom_range(99) < 20);
            redirect_enable = ($urandom_range(99) < 6);
            case ($urandom_range(3))
                0:       redirect_pc = $urandom();
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
                default: redirect_pc = $urandom() & 32'h0000_0FFF;
            endcase
            mem_bus.mem_ready = ($urandom_range(99) < 70);
            out_ready         = ($urandom_range(99) < 60);
            resp_prob         = ((i / 500) % 2 == 0) ? 60 : 90;
            cycle();
        end
        set_idle();
        reset = 1'b0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
